// File: rtl/floo_multi_link_xy_router.sv
// rtl/floo_multi_link_xy_router.sv - 5-port XY mesh router carrying NumLinks independent wormhole links
module floo_multi_link_xy_router #(
  parameter int unsigned NumLinks     = 2,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned InFifoDepth  = 2,
  parameter int unsigned DropCntWidth = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [2*IdWidth-1:0]               xy_id_i,
  input  logic [NumLinks*5-1:0]              valid_i,
  output logic [NumLinks*5-1:0]              ready_o,
  input  logic [NumLinks*5*DataWidth-1:0]    data_i,
  output logic [NumLinks*5-1:0]              valid_o,
  input  logic [NumLinks*5-1:0]              ready_i,
  output logic [NumLinks*5*DataWidth-1:0]    data_o,
  output logic [NumLinks*DropCntWidth-1:0]   drop_cnt_o
);

  localparam int unsigned NP = NumLinks * 5;
  localparam int unsigned IW = (InFifoDepth > 1) ? $clog2(InFifoDepth) : 1;
  localparam int unsigned CW = DropCntWidth + 3;

  typedef enum logic {IDLE, LOCKED} wh_state_e;

  logic [IdWidth-1:0]    my_x, my_y;
  logic [NP*DataWidth-1:0] head_flat;
  logic [NP*3-1:0]       route_flat;
  logic [NP*5-1:0]       xfer_flat;
  logic [NP-1:0]         head_valid, drop, pop;

  assign my_x = xy_id_i[IdWidth-1:0];
  assign my_y = xy_id_i[2*IdWidth-1:IdWidth];

  // Input side: one FIFO per link per port, route computed on its head.
  for (genvar p = 0; p < NP; p++) begin : g_in
    localparam int unsigned InBase = (p / 5) * 5;
    logic [DataWidth-1:0] mem [InFifoDepth];
    logic [IW-1:0]        wr_idx, rd_idx;
    logic                 wr_wrap, rd_wrap;
    logic                 full, push, pop_l;
    logic [IdWidth-1:0]   dx, dy;

    assign full          = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
    assign head_valid[p] = !((wr_idx == rd_idx) && (wr_wrap == rd_wrap));
    assign ready_o[p]    = !full;
    assign push          = valid_i[p] && !full;
    assign head_flat[p*DataWidth +: DataWidth] = mem[rd_idx];

    assign dx = mem[rd_idx][IdWidth-1:0];
    assign dy = mem[rd_idx][2*IdWidth-1:IdWidth];
    assign route_flat[3*p +: 3] = (dx > my_x) ? 3'd1 :
                                  (dx < my_x) ? 3'd3 :
                                  (dy > my_y) ? 3'd0 :
                                  (dy < my_y) ? 3'd2 : 3'd4;
    assign drop[p] = head_valid[p] && (p % 5 != 4) && (route_flat[3*p +: 3] == 3'(p % 5));

    always_comb begin
      pop_l = drop[p];
      for (int o = 0; o < 5; o++) begin
        pop_l = pop_l | xfer_flat[(InBase + o)*5 + (p % 5)];
      end
    end
    assign pop[p] = pop_l;

    always_ff @(posedge clk_i) begin
      if (push) mem[wr_idx] <= data_i[p*DataWidth +: DataWidth];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_idx  <= '0;
        rd_idx  <= '0;
        wr_wrap <= 1'b0;
        rd_wrap <= 1'b0;
      end else begin
        if (push) begin
          if (wr_idx == IW'(InFifoDepth - 1)) begin
            wr_idx  <= '0;
            wr_wrap <= !wr_wrap;
          end else begin
            wr_idx <= wr_idx + 1'b1;
          end
        end
        if (pop[p]) begin
          if (rd_idx == IW'(InFifoDepth - 1)) begin
            rd_idx  <= '0;
            rd_wrap <= !rd_wrap;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
      end
    end
  end

  // Output side: per link per output, round-robin arbiter with wormhole lock.
  for (genvar q = 0; q < NP; q++) begin : g_out
    localparam int unsigned Base = (q / 5) * 5;
    wh_state_e  state;
    logic [2:0] ptr, owner, hold_in, gidx, cand;
    logic       hold, gvalid, xfer, last;
    logic [4:0] req;

    always_comb begin
      for (int i = 0; i < 5; i++) begin
        req[i] = head_valid[Base+i] && !drop[Base+i] &&
                 (route_flat[3*(Base+i) +: 3] == 3'(q % 5));
      end
    end

    // A stalled grant is held so valid_o/data_o stay stable until accepted.
    always_comb begin
      gvalid = 1'b0;
      gidx   = ptr;
      cand   = '0;
      if (state == LOCKED) begin
        gidx   = owner;
        gvalid = req[owner];
      end else if (hold) begin
        gidx   = hold_in;
        gvalid = req[hold_in];
      end else begin
        for (int k = 4; k >= 0; k--) begin
          cand = 3'((int'(ptr) + k) % 5);
          if (req[cand]) begin
            gvalid = 1'b1;
            gidx   = cand;
          end
        end
      end
    end

    assign xfer       = gvalid && ready_i[q];
    assign last       = head_flat[(Base + int'(gidx))*DataWidth + 2*IdWidth];
    assign valid_o[q] = gvalid;
    assign data_o[q*DataWidth +: DataWidth] = head_flat[(Base + int'(gidx))*DataWidth +: DataWidth];
    assign xfer_flat[q*5 +: 5] = xfer ? (5'b00001 << gidx) : 5'b00000;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state   <= IDLE;
        owner   <= '0;
        ptr     <= '0;
        hold    <= 1'b0;
        hold_in <= '0;
      end else begin
        hold    <= gvalid && !ready_i[q];
        hold_in <= gidx;
        if (xfer) begin
          if (last) begin
            ptr   <= (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
            state <= IDLE;
          end else if (state == IDLE) begin
            state <= LOCKED;
            owner <= gidx;
          end
        end
      end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o[q] && !ready_i[q]) |=> (valid_o[q] && $stable(data_o[q*DataWidth +: DataWidth])));
  end

  for (genvar l = 0; l < NumLinks; l++) begin : g_cnt
    logic [DropCntWidth-1:0] cnt;
    logic [CW-1:0]           sum;

    always_comb begin
      sum = CW'(cnt);
      for (int r = 0; r < 4; r++) begin
        sum = sum + CW'(drop[l*5+r]);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt <= '0;
      end else if (sum > CW'({DropCntWidth{1'b1}})) begin
        cnt <= '1;
      end else begin
        cnt <= sum[DropCntWidth-1:0];
      end
    end
    assign drop_cnt_o[l*DropCntWidth +: DropCntWidth] = cnt;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown({valid_i, ready_i}));

endmodule

// File: tb/tb_floo_multi_link_xy_router.sv
// tb/tb_floo_multi_link_xy_router.sv - directed bench with route/drop scoreboard model
module tb_floo_multi_link_xy_router;
  localparam int NL = 2, DW = 64, IDW = 4, DEPTH = 2, DCW = 8, NP = NL * 5;
  localparam logic [3:0] MX = 4'd1, MY = 4'd1;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [2*IDW-1:0] xy_id_i;
  logic [NP-1:0] valid_i, ready_o, valid_o, ready_i;
  logic [NP*DW-1:0] data_i, data_o;
  logic [NL*DCW-1:0] drop_cnt_o;

  floo_multi_link_xy_router #(
    .NumLinks(NL), .DataWidth(DW), .IdWidth(IDW), .InFifoDepth(DEPTH), .DropCntWidth(DCW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .xy_id_i(xy_id_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [DW-1:0] exp_q [NP][$];
  logic [DW-1:0] stim_q [NP][$];
  int stim_delay [NP];
  int drop_model [NL];
  int first_cyc [NP], last_cyc [NP], xfer_cnt [NP];
  int fair_ports [4] = '{0, 2, 3, 4};
  bit auto_exp = 1'b1;

  function automatic logic [DW-1:0] mk(input logic [3:0] dx, input logic [3:0] dy,
                                       input logic last, input int tag);
    return {55'(tag), last, dy, dx};
  endfunction

  // Routing rule in plain arithmetic against this router's (1,1) position.
  function automatic int model_route(input logic [DW-1:0] f);
    if (f[3:0] > MX) return 1;
    if (f[3:0] < MX) return 3;
    if (f[7:4] > MY) return 0;
    if (f[7:4] < MY) return 2;
    return 4;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic model_accept(input int p, input logic [DW-1:0] f);
    int rt, r, l;
    rt = model_route(f);
    r = p % 5;
    l = p / 5;
    if (!auto_exp) return;
    if (r < 4 && rt == r) begin
      if (drop_model[l] < (1 << DCW) - 1) drop_model[l]++;
    end else begin
      exp_q[l*5+rt].push_back(f);
    end
  endtask

  task automatic clear_model();
    for (int q = 0; q < NP; q++) begin
      exp_q[q].delete();
      stim_q[q].delete();
      stim_delay[q] = 0;
      xfer_cnt[q] = 0;
    end
    for (int l = 0; l < NL; l++) drop_model[l] = 0;
  endtask

  // Every output, every cycle: transfers must match the expected queue, stalls must hold data.
  initial begin
    logic [NP-1:0] prev_stall;
    logic [DW-1:0] prev_data [NP];
    prev_stall = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = '0;
      end else begin
        for (int q = 0; q < NP; q++) begin
          if (prev_stall[q]) begin
            n_vec++;
            if (!valid_o[q] || data_o[q*DW +: DW] !== prev_data[q]) begin
              n_err++;
              $display("FAIL hold out%0d: valid %0b data %0h required valid 1 data %0h",
                       q, valid_o[q], data_o[q*DW +: DW], prev_data[q]);
            end
          end
          if (valid_o[q] && ready_i[q]) begin
            n_vec++;
            if (exp_q[q].size() == 0) begin
              n_err++;
              $display("FAIL unexpected out%0d: data %0h required none", q, data_o[q*DW +: DW]);
            end else begin
              if (data_o[q*DW +: DW] !== exp_q[q][0]) begin
                n_err++;
                $display("FAIL data out%0d: got %0h expected %0h", q, data_o[q*DW +: DW], exp_q[q][0]);
              end
              void'(exp_q[q].pop_front());
            end
            if (xfer_cnt[q] == 0) first_cyc[q] = cyc;
            last_cyc[q] = cyc;
            xfer_cnt[q]++;
          end
          prev_stall[q] = valid_o[q] && !ready_i[q];
          prev_data[q] = data_o[q*DW +: DW];
        end
      end
    end
  end

  task automatic run_stim(input int budget, input bit until_empty, output int used);
    bit empty;
    used = 0;
    while (used < budget) begin
      empty = 1'b1;
      for (int p = 0; p < NP; p++) if (stim_q[p].size() > 0) empty = 1'b0;
      if (until_empty && empty) break;
      for (int p = 0; p < NP; p++) begin
        if (stim_delay[p] == 0 && stim_q[p].size() > 0) begin
          valid_i[p] = 1'b1;
          data_i[p*DW +: DW] = stim_q[p][0];
        end else begin
          valid_i[p] = 1'b0;
        end
      end
      @(negedge clk_i);
      for (int p = 0; p < NP; p++) begin
        if (valid_i[p] && ready_o[p]) model_accept(p, stim_q[p].pop_front());
        if (stim_delay[p] > 0) stim_delay[p]--;
      end
      @(posedge clk_i); #1;
      used++;
    end
    valid_i = '0;
    if (until_empty) begin
      empty = 1'b1;
      for (int p = 0; p < NP; p++) if (stim_q[p].size() > 0) empty = 1'b0;
      check("stim_budget", empty, 1'b1);
    end
  endtask

  task automatic drain(input string name, input int budget);
    bit empty;
    for (int k = 0; k <= budget; k++) begin
      empty = 1'b1;
      for (int q = 0; q < NP; q++) if (exp_q[q].size() > 0) empty = 1'b0;
      if (empty) break;
      @(posedge clk_i); #1;
    end
    check(name, empty, 1'b1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input string name);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    valid_i = '0;
    #1;
    check({name, "_valid_o"}, valid_o, '0);
    check({name, "_drop"}, drop_cnt_o, '0);
    clear_model();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check({name, "_ready_o"}, ready_o, {NP{1'b1}});
    @(posedge clk_i); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    logic [DW-1:0] f;
    valid_i = '0;
    data_i = '0;
    ready_i = '1;
    xy_id_i = {MY, MX};
    rst_ni = 1'b0;
    clear_model();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("reset_valid_o", valid_o, '0);
    check("reset_ready_o", ready_o, {NP{1'b1}});
    check("reset_drop", drop_cnt_o, '0);
    @(posedge clk_i); #1;

    check("model_route_eject", model_route(mk(1, 1, 1, 0)), 4);
    check("model_route_south", model_route(mk(1, 0, 1, 0)), 2);
    check("model_route_west", model_route(mk(0, 2, 1, 0)), 3);
    check("model_route_east", model_route(mk(3, 1, 1, 0)), 1);

    // Straight West -> East, single-cycle latency, no fall-through.
    f = mk(3, 1, 1, 'h11);
    data_i[3*DW +: DW] = f;
    valid_i[3] = 1'b1;
    @(negedge clk_i);
    check("t1_ready", ready_o[3], 1'b1);
    check("t1_no_fallthrough", valid_o[1], 1'b0);
    model_accept(3, f);
    @(posedge clk_i); #1;
    valid_i[3] = 1'b0;
    @(negedge clk_i);
    check("t1_valid", valid_o[1], 1'b1);
    check("t1_data", data_o[1*DW +: DW], f);
    @(posedge clk_i); #1;
    drain("t1_drain", 10);

    // Link1: eject, YX turn to South, West.
    stim_q[5].push_back(mk(1, 1, 1, 'h21));
    stim_q[5].push_back(mk(0, 2, 1, 'h22));
    stim_q[6].push_back(mk(1, 0, 1, 'h23));
    run_stim(50, 1'b1, used);
    drain("t2_drain", 20);

    // Wormhole: South's single flit must wait for the whole West packet.
    auto_exp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      stim_q[3].push_back(mk(3, 1, (k == 3), 'h30 + k));
      exp_q[1].push_back(mk(3, 1, (k == 3), 'h30 + k));
    end
    stim_q[2].push_back(mk(2, 1, 1, 'h3f));
    exp_q[1].push_back(mk(2, 1, 1, 'h3f));
    stim_delay[2] = 2;
    run_stim(50, 1'b1, used);
    drain("t3_drain", 20);

    // Fairness from a fresh pointer: N,S,W,Local round-robin into East.
    do_reset("t4_rst");
    auto_exp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        stim_q[fair_ports[i]].push_back(mk(3, 1, 1, fair_ports[i]*16 + k));
        exp_q[1].push_back(mk(3, 1, 1, fair_ports[i]*16 + k));
      end
    end
    run_stim(60, 1'b1, used);
    drain("t4_drain", 20);
    check("t4_count", xfer_cnt[1], 12);
    check("t4_span", last_cyc[1] - first_cyc[1], 11);
    auto_exp = 1'b1;

    // U-turn drops: 300 flits back out East saturate link0's counter.
    for (int k = 0; k < 300; k++) stim_q[1].push_back(mk(5, 1, 1, k));
    run_stim(400, 1'b1, used);
    check("t5_ready_held", used, 300);
    wait_cycles(3);
    check("t5_drop0_model", drop_cnt_o[DCW-1:0], drop_model[0]);
    check("t5_drop0_sat", drop_cnt_o[DCW-1:0], 255);
    for (int k = 0; k < 3; k++) begin
      stim_q[5].push_back(mk(1, 3, 1, 'h50 + k));
      stim_q[7].push_back(mk(1, 0, 1, 'h60 + k));
      stim_q[8].push_back(mk(0, 1, 1, 'h70 + k));
    end
    run_stim(50, 1'b1, used);
    wait_cycles(3);
    check("t5_drop1_model", drop_cnt_o[2*DCW-1:DCW], drop_model[1]);
    check("t5_drop1_multi", drop_cnt_o[2*DCW-1:DCW], 9);
    drain("t5_no_output", 2);

    // Backpressure on link0 East mid-packet, link1 keeps flowing, then reset.
    for (int k = 0; k < 5; k++) stim_q[3].push_back(mk(3, 1, 0, 'h80 + k));
    run_stim(2, 1'b0, used);
    ready_i[1] = 1'b0;
    for (int k = 0; k < 4; k++) stim_q[8].push_back(mk(3, 1, 1, 'h90 + k));
    run_stim(10, 1'b0, used);
    @(negedge clk_i);
    check("t6_ready_low", ready_o[3], 1'b0);
    check("t6_accepted", stim_q[3].size(), 2);
    check("t6_stalled_valid", valid_o[1], 1'b1);
    check("t6_link1_done", stim_q[8].size(), 0);
    check("t6_link1_out", exp_q[6].size(), 0);
    @(posedge clk_i); #1;
    do_reset("t6_rst");
    ready_i = '1;
    stim_q[2].push_back(mk(3, 1, 1, 'ha1));
    run_stim(20, 1'b1, used);
    drain("t6_lock_cleared", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
